// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx: I2S transmitter at the codec end of the sample path.
// Emits the frame-rate new_frame strobe that paces the upstream player and
// serializes the held 16-bit sample, MSB first with the I2S one-bit delay,
// into both the left and right 32-bit slots. BCLK_HALF must be >= 2.
// Every output is a flop; inputs only reach outputs through registered state.

module i2s_sample_tx #(
  parameter int BCLK_HALF = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        mute,
  output logic        new_frame,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata
);

  localparam int DIV_W = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic [15:0]      hold;

  logic             div_wrap;
  logic             fall_evt;
  logic             frame_evt;
  logic [5:0]       bit_nxt;
  logic [4:0]       slot_pos;
  logic [3:0]       msb_idx;
  logic             slot_bit;

  // A fall event is the divider wrap while bclk is high; the bit counter
  // advances there, so all slot decoding looks at the post-increment count.
  assign div_wrap  = (div_cnt == DIV_LAST);
  assign fall_evt  = div_wrap & bclk;
  assign bit_nxt   = bit_cnt + 6'd1;
  assign frame_evt = fall_evt & (bit_nxt == 6'd0);
  assign slot_pos  = bit_nxt[4:0];
  assign msb_idx   = 4'(5'd16 - slot_pos);

  // Data bit for the slot position about to start; zero in the delay bit and pad
  always_comb begin
    slot_bit = 1'b0;
    if ((slot_pos >= 5'd1) && (slot_pos <= 5'd16)) begin
      slot_bit = hold[msb_idx];
    end
  end

  // Half-period divider for the bit clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_wrap) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Bit clock toggles at every divider wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk <= 1'b0;
    end else if (div_wrap) begin
      bclk <= ~bclk;
    end
  end

  // Bit position within the frame and word select; reset to 63 so the first
  // fall event after reset wraps to 0 and opens a frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= 6'd63;
      lrclk   <= 1'b0;
    end else if (fall_evt) begin
      bit_cnt <= bit_nxt;
      lrclk   <= bit_nxt[5];
    end
  end

  // Capture the upstream sample once per frame; it stays fixed for both slots
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= 16'h0000;
    end else if (frame_evt) begin
      hold <= sample_in;
    end
  end

  // Serial data launches with the bclk falling edge; mute is applied per bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sdata <= 1'b0;
    end else if (fall_evt) begin
      sdata <= mute ? 1'b0 : slot_bit;
    end
  end

  // One-cycle frame strobe following the wrap to bit 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      new_frame <= 1'b0;
    end else begin
      new_frame <= frame_evt;
    end
  end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: two instances (BCLK_HALF 8 and 2) against an
// arithmetic reference derived from the clk edge count since reset release.

module tb_i2s_sample_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        mute;
  logic        nf8, bclk8, lr8, sd8;
  logic        nf2, bclk2, lr2, sd2;

  always #5 clk = ~clk;

  i2s_sample_tx #(.BCLK_HALF(8)) dut8 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .mute(mute),
    .new_frame(nf8), .bclk(bclk8), .lrclk(lr8), .sdata(sd8)
  );

  i2s_sample_tx #(.BCLK_HALF(2)) dut2 (
    .clk(clk), .reset(reset), .sample_in(sample_in), .mute(mute),
    .new_frame(nf2), .bclk(bclk2), .lrclk(lr2), .sdata(sd2)
  );

  // Reference: after the k-th edge since release, bclk = (k/H) mod 2; a fall
  // happens when k is a multiple of 2H, and fall number f puts the frame at
  // bit (f+63) mod 64. Bit 0 latches the sample and fires new_frame.
  localparam int HV [2] = '{8, 2};
  int          m_k    [2];
  logic        m_bclk [2];
  logic        m_lr   [2];
  logic        m_sd   [2];
  logic        m_nf   [2];
  logic [15:0] m_hold [2];

  always @(posedge clk or negedge reset) begin
    int kn, h, b, p;
    logic [15:0] hv;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_k[i] <= 0; m_bclk[i] <= 1'b0; m_lr[i] <= 1'b0;
        m_sd[i] <= 1'b0; m_nf[i] <= 1'b0; m_hold[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        h  = HV[i];
        kn = m_k[i] + 1;
        m_k[i]    <= kn;
        m_bclk[i] <= (((kn / h) % 2) == 1);
        m_nf[i]   <= 1'b0;
        if ((kn % (2 * h)) == 0) begin
          b  = ((kn / (2 * h)) + 63) % 64;
          hv = (b == 0) ? sample_in : m_hold[i];
          m_hold[i] <= hv;
          m_lr[i]   <= (b >= 32);
          p = b % 32;
          m_sd[i]   <= (!mute && p >= 1 && p <= 16) ? hv[16 - p] : 1'b0;
          m_nf[i]   <= (b == 0);
        end
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling clk edge and compare both instances to the model
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      check("model_h8", 64'({bclk8, lr8, sd8, nf8}),
            64'({m_bclk[0], m_lr[0], m_sd[0], m_nf[0]}));
      check("model_h2", 64'({bclk2, lr2, sd2, nf2}),
            64'({m_bclk[1], m_lr[1], m_sd[1], m_nf[1]}));
    end
  endtask

  task automatic reset_release_timing();
    int t8[$];
    int t2[$];
    int cyc = 0;
    int hi8 = 0;
    logic p8 = 1'b0;
    logic p2 = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    while ((t8.size() < 2 || t2.size() < 2) && cyc < 3000) begin
      tick();
      cyc++;
      if (nf8 && t8.size() < 2) begin
        hi8++;
        if (!p8) t8.push_back(cyc);
      end
      if (nf2 && !p2 && t2.size() < 2) t2.push_back(cyc);
      p8 = nf8;
      p2 = nf2;
    end
    check("nf8_pulses_seen", 64'(t8.size()), 64'd2);
    check("nf2_pulses_seen", 64'(t2.size()), 64'd2);
    check("nf8_first_edge", 64'((t8.size() > 0) ? t8[0] : -1), 64'd16);
    check("nf8_period", 64'((t8.size() > 1) ? t8[1] - t8[0] : -1), 64'd1024);
    check("nf8_width_cycles", 64'(hi8), 64'd2);
    check("nf2_first_edge", 64'((t2.size() > 0) ? t2[0] : -1), 64'd4);
    check("nf2_period", 64'((t2.size() > 1) ? t2[1] - t2[0] : -1), 64'd256);
  endtask

  task automatic wait_frame();
    int g = 0;
    do begin
      tick();
      g++;
    end while (!nf8 && g < 1100);
    check("frame_wait", 64'(nf8), 64'd1);
  endtask

  // Record sdata/lrclk at 64 bclk rises of the H=8 instance; optionally change
  // inputs right after rise number chg_at
  task automatic capture_frame(input int chg_at, input logic [15:0] chg_smp,
                               input logic chg_mt,
                               output logic [63:0] sd, output logic [63:0] lr);
    int n = 0;
    int g = 0;
    logic prev;
    sd = '0;
    lr = '0;
    prev = bclk8;
    while (n < 64 && g < 2200) begin
      tick();
      g++;
      if (bclk8 && !prev) begin
        sd[n] = sd8;
        lr[n] = lr8;
        if (n == chg_at) begin
          sample_in = chg_smp;
          mute = chg_mt;
        end
        n++;
      end
      prev = bclk8;
    end
    check("capture_bits", 64'(n), 64'd64);
  endtask

  typedef struct {
    logic [15:0] smp;
    logic        mt;
    int          chg_at;
    logic [15:0] chg_smp;
    logic        chg_mt;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [63:0] sd, lr, zm;
    logic [15:0] wl, wr;
    int n, g;
    logic prev;

    tbl[0] = '{16'hA5C3, 1'b0, -1, 16'h0000, 1'b0, 16'hA5C3, 16'hA5C3};
    tbl[1] = '{16'hA5C3, 1'b0,  8, 16'h1234, 1'b0, 16'hA5C3, 16'hA5C3};
    tbl[2] = '{16'h1234, 1'b0, -1, 16'h0000, 1'b0, 16'h1234, 16'h1234};
    tbl[3] = '{16'hFFFF, 1'b1, -1, 16'h0000, 1'b1, 16'h0000, 16'h0000};
    tbl[4] = '{16'hFFFF, 1'b1,  8, 16'hFFFF, 1'b0, 16'h00FF, 16'hFFFF};
    tbl[5] = '{16'hFFFF, 1'b0, -1, 16'h0000, 1'b0, 16'hFFFF, 16'hFFFF};
    tbl[6] = '{16'h8001, 1'b0, -1, 16'h0000, 1'b0, 16'h8001, 16'h8001};
    tbl[7] = '{16'h0000, 1'b0, -1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[8] = '{16'h7FFE, 1'b1, 32, 16'h7FFE, 1'b0, 16'h0000, 16'h7FFE};

    zm = '0;
    for (int j = 0; j < 64; j++) if ((j % 32) == 0 || (j % 32) > 16) zm[j] = 1'b1;

    sample_in = 16'h0000;
    mute = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (5) tick();
    check("reset_out_h8", 64'({bclk8, lr8, sd8, nf8}), 64'd0);
    check("reset_out_h2", 64'({bclk2, lr2, sd2, nf2}), 64'd0);

    reset_release_timing();

    for (int i = 0; i < 9; i++) begin
      sample_in = tbl[i].smp;
      mute = tbl[i].mt;
      wait_frame();
      capture_frame(tbl[i].chg_at, tbl[i].chg_smp, tbl[i].chg_mt, sd, lr);
      for (int j = 0; j < 16; j++) begin
        wl[15 - j] = sd[1 + j];
        wr[15 - j] = sd[33 + j];
      end
      check($sformatf("vec%0d_left", i), 64'(wl), 64'(tbl[i].exp_l));
      check($sformatf("vec%0d_right", i), 64'(wr), 64'(tbl[i].exp_r));
      check($sformatf("vec%0d_pad_zero", i), sd & zm, 64'd0);
      check($sformatf("vec%0d_lrclk", i), lr, {32'hFFFF_FFFF, 32'h0000_0000});
    end

    for (int c = 0; c < 6 * 1024; c++) begin
      if ($urandom_range(63) == 0) mute = ~mute;
      if ($urandom_range(199) == 0) sample_in = 16'($urandom());
      tick();
    end
    mute = 1'b0;

    sample_in = 16'hC0DE;
    wait_frame();
    n = 0;
    g = 0;
    prev = bclk8;
    while (n <= 40 && g < 2000) begin
      tick();
      g++;
      if (bclk8 && !prev) n++;
      prev = bclk8;
    end
    check("midframe_reached", 64'(n), 64'd41);
    check("midframe_lrclk_high", 64'({bclk8, lr8}), 64'b11);
    #2 reset = 1'b0;
    #1;
    check("midframe_reset_h8", 64'({bclk8, lr8, sd8, nf8}), 64'd0);
    check("midframe_reset_h2", 64'({bclk2, lr2, sd2, nf2}), 64'd0);
    repeat (5) tick();
    reset_release_timing();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
